// File: rtl/dot_matrix_drv_if.sv
// Upstream column-scan bus between the character scanner and the LED panel driver.
//   scan_en : one-cycle strobe, column data valid
//   col_in  : column index 0..15
//   row_in  : row pattern for that column, 1 = LED on
//   bright  : brightness level 0..7, sampled with scan_en
// master = scanner side (drives), slave = panel driver side (receives).
interface dot_matrix_drv_if;
  logic        scan_en;
  logic [3:0]  col_in;
  logic [15:0] row_in;
  logic [2:0]  bright;

  modport master (output scan_en, col_in, row_in, bright);
  modport slave  (input  scan_en, col_in, row_in, bright);
endinterface

// File: rtl/dot_matrix_drv.sv
// Dot-matrix LED panel column driver.
// Takes one column at a time from the upstream scanner and drives it onto the
// panel after a fixed blanking gap. Brightness is set by a 3-bit PWM on the
// row lines. A column left without a new strobe for TIMEOUT cycles is switched
// off.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   scan           : upstream column bus (slave side)
//   col_sel[15:0]  : active-low one-hot column select
//   row_out[15:0]  : active-high row drive
//   blank          : high while the panel is not driven
//   frame_tick     : one-cycle pulse when column 15 starts being driven
module dot_matrix_drv #(
  parameter int unsigned BLANK_CYC = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  dot_matrix_drv_if.slave    scan,
  output logic [15:0]        col_sel,
  output logic [15:0]        row_out,
  output logic               blank,
  output logic               frame_tick
);

  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 16;
  localparam int unsigned BRT_W = 3;
  localparam int unsigned BLK_W = 4;
  localparam int unsigned TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [BRT_W-1:0]   bright_q;
  logic [BLK_W-1:0]   blank_cnt;
  logic [BRT_W-1:0]   pwm_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  // Column select for the latched column, and the PWM phase of the next cycle.
  logic [ROW_W-1:0]   col_drive;
  logic [BRT_W-1:0]   pwm_next;

  assign col_drive = ~(ROW_W'(1) << col_q);
  assign pwm_next  = pwm_cnt + BRT_W'(1);

  // Outputs are computed for the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      bright_q   <= '0;
      blank_cnt  <= '0;
      pwm_cnt    <= '0;
      tmo_cnt    <= '0;
      col_sel    <= '1;
      row_out    <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else if (scan.scan_en) begin
      // A new column wins over every expiry and restarts the blanking gap.
      state      <= BLANK;
      col_q      <= scan.col_in;
      row_q      <= scan.row_in;
      bright_q   <= scan.bright;
      blank_cnt  <= BLK_W'(BLANK_CYC);
      pwm_cnt    <= '0;
      tmo_cnt    <= '0;
      col_sel    <= '1;
      row_out    <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          col_sel <= '1;
          row_out <= '0;
          blank   <= 1'b1;
        end
        BLANK: begin
          if (blank_cnt == BLK_W'(1)) begin
            // Last blank cycle: enter DRIVE at PWM phase 0, which always lights.
            state      <= DRIVE;
            pwm_cnt    <= '0;
            tmo_cnt    <= '0;
            col_sel    <= col_drive;
            row_out    <= row_q;
            blank      <= 1'b0;
            frame_tick <= (col_q == COL_W'(15));
          end else begin
            blank_cnt <= blank_cnt - BLK_W'(1);
            col_sel   <= '1;
            row_out   <= '0;
            blank     <= 1'b1;
          end
        end
        DRIVE: begin
          if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state   <= IDLE;
            col_sel <= '1;
            row_out <= '0;
            blank   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            pwm_cnt <= pwm_next;
            col_sel <= col_drive;
            row_out <= (pwm_next <= bright_q) ? row_q : '0;
            blank   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          col_sel <= '1;
          row_out <= '0;
          blank   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_matrix_drv.sv
// Self-checking bench for dot_matrix_drv: directed scenarios plus random
// strobes, compared every cycle against a timeline model of the panel.
module tb_dot_matrix_drv;

  localparam int unsigned B   = 4;
  localparam int unsigned TMO = 1024;

  logic        clk;
  logic        reset;
  logic [15:0] col_sel;
  logic [15:0] row_out;
  logic        blank;
  logic        frame_tick;

  dot_matrix_drv_if bus ();

  dot_matrix_drv #(.BLANK_CYC(B), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan       (bus.slave),
    .col_sel    (col_sel),
    .row_out    (row_out),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: time since the last accepted strobe decides everything.
  bit          m_valid;
  int          m_since;
  logic [3:0]  m_col;
  logic [15:0] m_row;
  logic [2:0]  m_br;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_now(input string tag);
    check({tag, "_col"},   col_sel, 16'hFFFF);
    check({tag, "_row"},   row_out, 16'h0000);
    check({tag, "_blank"}, 16'(blank), 16'h1);
    check({tag, "_tick"},  16'(frame_tick), 16'h0);
  endtask

  task automatic check_model();
    logic [15:0] e_col, e_row;
    logic        e_blank, e_tick;
    int k;
    e_col = 16'hFFFF; e_row = 16'h0000; e_blank = 1'b1; e_tick = 1'b0;
    if (m_valid && m_since > int'(B)) begin
      k = m_since - int'(B) - 1;
      if (k < int'(TMO)) begin
        e_col   = ~(16'h0001 << m_col);
        e_row   = ((k % 8) <= int'(m_br)) ? m_row : 16'h0000;
        e_blank = 1'b0;
        e_tick  = (k == 0) && (m_col == 4'd15);
      end
    end
    check("col_sel", col_sel, e_col);
    check("row_out", row_out, e_row);
    check("blank", 16'(blank), 16'(e_blank));
    check("frame_tick", 16'(frame_tick), 16'(e_tick));
    check("one_hot", 16'($countones(~col_sel) <= 1), 16'h1);
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge.
  task automatic cycle(input bit se, input logic [3:0] c, input logic [15:0] r, input logic [2:0] b);
    bus.scan_en = se; bus.col_in = c; bus.row_in = r; bus.bright = b;
    @(posedge clk);
    if (se) begin
      m_valid = 1'b1; m_since = 1; m_col = c; m_row = r; m_br = b;
    end else if (m_valid && m_since < 1000000) begin
      m_since++;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 16'h0000, 3'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1 check_idle_now(tag);
    m_valid = 1'b0; m_since = 0;
    @(negedge clk);
    check_idle_now({tag, "_held"});
    reset = 1'b1;
  endtask

  int ticks;

  initial begin
    m_valid = 1'b0; m_since = 0; m_col = '0; m_row = '0; m_br = '0;
    reset = 1'b0;
    bus.scan_en = 1'b0; bus.col_in = '0; bus.row_in = '0; bus.bright = '0;
    repeat (3) @(negedge clk);
    check_idle_now("reset");
    reset = 1'b1;
    idle_cycles(3);

    // Column 3, full brightness: 4 blank cycles then FFF7 / A5A5 steady.
    cycle(1'b1, 4'd3, 16'hA5A5, 3'd7);
    idle_cycles(B + 20);
    check("bright7_col", col_sel, 16'hFFF7);
    check("bright7_row", row_out, 16'hA5A5);

    // bright 1: two of every eight drive cycles lit.
    cycle(1'b1, 4'd9, 16'hFFFF, 3'd1);
    idle_cycles(B);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      if (row_out == 16'hFFFF) ticks++;
      cycle(1'b0, 4'd0, 16'h0000, 3'd0);
    end
    check("bright1_duty", 16'(ticks), 16'd4);

    // bright 0: one of eight.
    cycle(1'b1, 4'd0, 16'h1234, 3'd0);
    idle_cycles(B + 17);

    // frame_tick only for column 15, exactly once.
    cycle(1'b1, 4'd15, 16'h00FF, 3'd4);
    ticks = 0;
    for (int i = 0; i < int'(B) + 10; i++) begin
      cycle(1'b0, 4'd0, 16'h0000, 3'd0);
      if (frame_tick) ticks++;
    end
    check("tick_col15", 16'(ticks), 16'd1);
    cycle(1'b1, 4'd14, 16'h00FF, 3'd4);
    ticks = 0;
    for (int i = 0; i < int'(B) + 10; i++) begin
      cycle(1'b0, 4'd0, 16'h0000, 3'd0);
      if (frame_tick) ticks++;
    end
    check("tick_col14", 16'(ticks), 16'd0);

    // Timeout: drive for exactly TMO cycles then blank.
    cycle(1'b1, 4'd5, 16'hBEEF, 3'd7);
    idle_cycles(B + TMO + 3);
    check_idle_now("timeout");

    // Restrike two cycles into BLANK: full blank restarts, second data shown.
    cycle(1'b1, 4'd1, 16'h1111, 3'd7);
    idle_cycles(2);
    cycle(1'b1, 4'd2, 16'h2222, 3'd7);
    idle_cycles(B + 3);
    check("restrike_col", col_sel, 16'hFFFB);
    check("restrike_row", row_out, 16'h2222);

    // Strobe on the last blank cycle takes priority over entering DRIVE.
    cycle(1'b1, 4'd6, 16'h6666, 3'd3);
    idle_cycles(B - 1);
    cycle(1'b1, 4'd7, 16'h7777, 3'd3);
    idle_cycles(B + 9);

    // Strobe during DRIVE blanks on the next clock.
    cycle(1'b1, 4'd8, 16'h8888, 3'd6);
    idle_cycles(B + 5);
    cycle(1'b1, 4'd10, 16'hAAAA, 3'd2);
    check_idle_now("drive_restrike");
    idle_cycles(B + 4);

    // Strobe on the last DRIVE cycle takes priority over the timeout.
    cycle(1'b1, 4'd11, 16'hCAFE, 3'd5);
    idle_cycles(B + TMO - 1);
    cycle(1'b1, 4'd12, 16'hF00D, 3'd5);
    idle_cycles(B + 12);

    // Async reset mid-DRIVE, then normal recovery.
    async_reset("reset_drive");
    idle_cycles(2);
    cycle(1'b1, 4'd4, 16'h0F0F, 3'd7);
    idle_cycles(B + 3);
    check("recover_col", col_sel, 16'hFFEF);

    // Async reset mid-BLANK.
    cycle(1'b1, 4'd13, 16'h1357, 3'd2);
    idle_cycles(1);
    async_reset("reset_blank");
    idle_cycles(B + 3);

    // Random strobes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(11) == 0)
        cycle(1'b1, 4'($urandom_range(15)), 16'($urandom), 3'($urandom_range(7)));
      else
        cycle(1'b0, 4'($urandom_range(15)), 16'($urandom), 3'($urandom_range(7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
